// File: rtl/regfile_pkg.sv
// Shared register-file constants: geometry, the hard-wired zero register and
// the write-back requester slot assignments.
package regfile_pkg;

  localparam int          REG_AW    = 5;
  localparam int          REG_WIDTH = 32;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_CP0  = 2;

  localparam int WB_NREQ = 3;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the requesters (master) and the arbiter (slave),
// including the registered register-file write port driven by the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32,
  parameter int AW    = 5
);

  logic                      hold;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*AW-1:0]        req_addr;
  logic [NREQ*WIDTH-1:0]     req_data;
  logic                      rf_we;
  logic [AW-1:0]             rf_waddr;
  logic [WIDTH-1:0]          rf_wdata;
  logic [$clog2(NREQ)-1:0]   grant_id;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_waddr, rf_wdata, grant_id
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational requester picker: first set bit scanning upward from i_ptr
// with wrap. With REGARB_FIXED_PRIO_EN defined the pointer is ignored.
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IW = $clog2(NREQ);

  logic          r_found;
  logic [IW-1:0] w_j;
`ifndef REGARB_FIXED_PRIO_EN
  logic [IW:0]   w_sum;
`else
  logic          w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
`endif

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    r_found = 1'b0;
    w_j     = '0;
`ifndef REGARB_FIXED_PRIO_EN
    w_sum   = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef REGARB_FIXED_PRIO_EN
      w_j = IW'(k);
`else
      // one extra bit so ptr+k never overflows before the modulo fold
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ))
        w_sum = w_sum - (IW+1)'(NREQ);
      w_j = w_sum[IW-1:0];
`endif
      if (!r_found && i_req[w_j]) begin
        r_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: picks one
// requester per cycle and registers its write. Option: REGARB_FIXED_PRIO_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = WB_NREQ,
  parameter int WIDTH = REG_WIDTH,
  parameter int AW    = REG_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0][AW-1:0]    w_addr;
  logic [NREQ-1:0][WIDTH-1:0] w_data;
  logic [NREQ-1:0]            w_req;
  logic [NREQ-1:0]            w_gnt;
  logic [IW-1:0]              w_idx;
  logic [IW-1:0]              w_ptr;
  logic                       w_fire;
  logic [AW-1:0]              w_sel_addr;
  logic [WIDTH-1:0]           w_sel_data;

  logic                       r_we;
  logic [AW-1:0]              r_waddr;
  logic [WIDTH-1:0]           r_wdata;
  logic [IW-1:0]              r_gid;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr[g] = bus.req_addr[g*AW +: AW];
    assign w_data[g] = bus.req_data[g*WIDTH +: WIDTH];
  end

  // reset level gates the request vector so ready is held low during reset
  assign w_req = (reset && !bus.hold) ? bus.req_valid : '0;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_fire        = |w_gnt;
  assign w_sel_addr    = w_addr[w_idx];
  assign w_sel_data    = w_data[w_idx];
  assign bus.req_ready = w_gnt;

`ifdef REGARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IW-1:0] r_ptr;
  assign w_ptr = r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ptr <= '0;
    else if (w_fire)
      r_ptr <= (w_idx == IW'(NREQ-1)) ? '0 : w_idx + IW'(1);
  end
`endif

  // r0 writes are still consumed; only the enable is suppressed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_gid   <= '0;
    end else begin
      r_we <= w_fire && (w_sel_addr != AW'(REG_ZERO));
      if (w_fire) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        r_gid   <= w_idx;
      end
    end
  end

  assign bus.rf_we    = r_we;
  assign bus.rf_waddr = r_waddr;
  assign bus.rf_wdata = r_wdata;
  assign bus.grant_id = r_gid;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus queues expected register-file writes, a negedge
// monitor pops and compares each one the DUT presents.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int W    = 32;
  localparam int AW   = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .WIDTH(W), .AW(AW)) bus();

  regfile_wb_arbiter #(.NREQ(NREQ), .WIDTH(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic [1:0]    g;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

`ifdef REGARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input logic [31:0] d, input int g);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    e.g = 2'(g);
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input bit v, input int a, input logic [31:0] d);
    bus.req_valid[i]           = v;
    bus.req_addr[i*AW +: AW]   = AW'(a);
    bus.req_data[i*W +: W]     = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 32'h0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h gid %0d, required no write",
                 bus.rf_waddr, bus.rf_wdata, bus.grant_id);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(e.a));
        chk("wr_data", bus.rf_wdata, e.d);
        chk("wr_gid",  32'(bus.grant_id), 32'(e.g));
      end
    end
  end

  initial begin
    int g, g1, g2;
    bus.hold = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 32'h55);

    // reset state, with all requesters valid
    #12;
    chk("rst_we",    32'(bus.rf_we), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_gid",   32'(bus.grant_id), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    clear_all();
    step();
    reset = 1'b1;

    // single request from the load unit
    set_req(WB_LOAD, 1'b1, 5, 32'h1234);
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'b010);
    push(5, 32'h1234, WB_LOAD);
    step();
    set_req(WB_LOAD, 1'b0, 0, 32'h0);
    chk("t1_we",  32'(bus.rf_we), 32'd1);
    chk("t1_gid", 32'(bus.grant_id), 32'd1);
    step();

    // restart from pointer 0, all three continuously valid
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 32'h100 + i);
    for (int k = 0; k < 6; k++) begin
      g = FIXED ? 0 : k % 3;
      @(negedge clk);
      chk("t2_ready", 32'(bus.req_ready), 32'(1 << g));
      push(g + 1, 32'h100 + g, g);
      step();
    end
    clear_all();

    // r0 write: consumed, no enable
    set_req(WB_ALU, 1'b1, 0, 32'hFFFF);
    @(negedge clk);
    chk("t3_ready", 32'(bus.req_ready), 32'b001);
    step();
    clear_all();
    chk("t3_we",  32'(bus.rf_we), 32'd0);
    chk("t3_gid", 32'(bus.grant_id), 32'd0);

    // hold for three cycles, then resume in pointer order
    bus.hold = 1'b1;
    set_req(0, 1'b1, 10, 32'hA0);
    set_req(2, 1'b1, 12, 32'hA2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("t4_hold_we", 32'(bus.rf_we), 32'd0);
    end
    bus.hold = 1'b0;
    g1 = FIXED ? 0 : 2;
    g2 = FIXED ? 2 : 0;
    @(negedge clk);
    chk("t4_ready_a", 32'(bus.req_ready), 32'(1 << g1));
    push(10 + g1, 32'hA0 + g1, g1);
    step();
    set_req(g1, 1'b0, 0, 32'h0);
    @(negedge clk);
    chk("t4_ready_b", 32'(bus.req_ready), 32'(1 << g2));
    push(10 + g2, 32'hA0 + g2, g2);
    step();
    clear_all();

    // reset right after a grant drops the pending write
    set_req(WB_LOAD, 1'b1, 7, 32'hABCD);
    @(negedge clk);
    chk("t5_ready", 32'(bus.req_ready), 32'b010);
    step();
    reset = 1'b0;
    set_req(1, 1'b1, 8, 32'hB1);
    set_req(2, 1'b1, 9, 32'hB2);
    #1;
    chk("t5_we",    32'(bus.rf_we), 32'd0);
    chk("t5_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("t5_wdata", bus.rf_wdata, 32'd0);
    chk("t5_gid",   32'(bus.grant_id), 32'd0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_first", 32'(bus.req_ready), 32'b010);
    push(8, 32'hB1, 1);
    step();
    set_req(1, 1'b0, 0, 32'h0);
    @(negedge clk);
    chk("t5_second", 32'(bus.req_ready), 32'b100);
    push(9, 32'hB2, 2);
    step();
    clear_all();

    // requesters 0 and 2 continuously valid
    set_req(0, 1'b1, 4, 32'hC0);
    set_req(2, 1'b1, 6, 32'hC2);
    for (int k = 0; k < 4; k++) begin
      g = FIXED ? 0 : ((k % 2) ? 2 : 0);
      @(negedge clk);
      chk("t6_ready", 32'(bus.req_ready), 32'(1 << g));
      push(4 + g, 32'hC0 + g, g);
      step();
    end
    clear_all();

    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("idle_we", 32'(bus.rf_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32×32 general register file's single write port. It shares that port between up to `NREQ` write-back requesters (ALU result, memory load, coprocessor/debug write) using round-robin selection and valid/ready handshakes. It drives the register file's write-enable, write-address and write-data inputs from a registered output stage. It sits between the execution/memory units and the register file, on the same clock domain.

## Interface
Parameters:
- `NREQ`, 3, number of requesters; 2..8
- `WIDTH`, 32, data width
- `AW`, 5, register address width

Ports:
- `clk`  in  1  system clock; arbiter state updates on posedge
- `reset`  in  1  asynchronous, active-low reset
- `hold`  in  1  pipeline stall; while 1, no grants are issued
- `req_valid`  in  NREQ  per-requester write request
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero
- `req_addr`  in  NREQ*AW  packed destination register numbers; requester i occupies bits [i*AW +: AW]
- `req_data`  in  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  AW  register-file write address (registered)
- `rf_wdata`  out  WIDTH  register-file write data (registered)
- `grant_id`  out  $clog2(NREQ)  index of the requester that last won (registered)

## Operation
- Handshake: a transfer from requester i occurs on a posedge where `req_valid[i]` and `req_ready[i]` are both 1.
- Requesters hold `valid`, `addr` and `data` stable until they are accepted. Valid is never withdrawn before acceptance.
- `req_ready` is combinational from `req_valid`, `hold` and the priority pointer `ptr`.
- When `hold` is 0, exactly one ready is asserted: the first valid requester found scanning indices ptr, ptr+1, … (mod NREQ).
- No valid requester, or `hold`=1: all ready bits are 0.
- On each accepted transfer from requester i:
  - `rf_waddr` ← addr_i, `rf_wdata` ← data_i, `grant_id` ← i, `ptr` ← (i+1) mod NREQ.
  - `rf_we` ← 1, except when addr_i == 0. A write to r0 is accepted and consumed, but `rf_we` ← 0 so r0 stays 0.
- Cycles with no transfer: `rf_we` ← 0. `rf_waddr`, `rf_wdata` and `grant_id` hold their values. `ptr` is unchanged.
- Pointer wrap: a grant to index NREQ-1 sets `ptr` to 0.
- Throughput is one write per cycle. Each requester waits at most NREQ-1 grant cycles while it is valid and `hold`=0.

## Timing
- Reset (asynchronous, `reset`=0): `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `grant_id`=0, `ptr`=0. `req_ready` is forced to 0 while reset is asserted.
- Reset mid-operation: a registered write not yet consumed is discarded. After reset deasserts, arbitration restarts from requester 0.
- Latency: a transfer accepted at posedge N drives `rf_we`/`rf_waddr`/`rf_wdata` during the cycle from N to N+1. The register file samples them on the negedge inside that cycle.
- Outputs are stable from posedge to the following posedge, so the negedge write always sees settled values.
- `hold` asserted in cycle N: no transfer at posedge N, and `rf_we`=0 in the following cycle.
- Simultaneous events:
  - With all requesters valid continuously from `ptr`=0, grants go 0,1,2,0,1,…
  - Two requesters targeting the same register in consecutive cycles are written in grant order; the later grant wins.
- There is no combinational path from any input to `rf_*` or `grant_id`.

## Configuration
- `REGARB_FIXED_PRIO_EN` defined:
  - Selection is fixed priority: the lowest-index valid requester wins.
  - `ptr` is not implemented.
  - A continuously valid requester 0 can starve the others.
- Not defined: round-robin as described in Operation.
- All other behaviour is identical with and without the macro.

## Structure
- Shared package `regfile_pkg` contains:
  - `REG_AW` = 5, `REG_WIDTH` = 32, `REG_ZERO` = 5'd0
  - the requester index constants `WB_ALU` = 0, `WB_LOAD` = 1, `WB_CP0` = 2
- One sub-module, `rr_pick`, is natural:
  - inputs: NREQ request vector and start pointer
  - outputs: one-hot grant and encoded index
  - combinational
  - under `REGARB_FIXED_PRIO_EN` it ignores the pointer
- The top level holds the output register stage and the pointer.

## Test plan
- Reset → all outputs 0, `req_ready`=0. Release reset, drive valid[1] with addr 5, data 0x1234 → ready[1]=1 that cycle; the next cycle shows `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `grant_id`=1.
- All three requesters valid continuously from reset (addr 1/2/3) → grants in order 0,1,2,0,1,2. `rf_we`=1 every cycle and `rf_waddr` follows 1,2,3,1,2,3.
- Requester 0 writes addr 0, data 0xFFFF → ready[0]=1 and the request is consumed; `rf_we`=0 the next cycle.
- `hold`=1 for 3 cycles with requesters 0 and 2 valid → ready=0 throughout and `rf_we`=0 after the first cycle. Release `hold` → grants resume in pointer order.
- Reset asserted the cycle after a grant (addr 7, data 0xABCD) → `rf_we` drops to 0 immediately and the write is lost. The first grant after reset goes to the lowest valid index.
- With `REGARB_FIXED_PRIO_EN` defined, requesters 0 and 2 valid for 4 cycles → requester 0 is granted every cycle and ready[2] stays 0.
